// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, recode opcodes, helpers.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NOP,
        ADD1,
        SUB1,
        ADD2,
        SUB2
    } booth_op_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Radix-2 looks at the current bit and the bit shifted out last step.
    function automatic booth_op_t recode2(input logic [1:0] g);
        case (g)
            2'b01:   return ADD1;
            2'b10:   return SUB1;
            default: return NOP;
        endcase
    endfunction

    function automatic booth_op_t recode4(input logic [2:0] g);
        case (g)
            3'b001, 3'b010: return ADD1;
            3'b011:         return ADD2;
            3'b100:         return SUB2;
            3'b101, 3'b110: return SUB1;
            default:        return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
interface booth_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] out_c;

    modport master (
        output start, signed_mode, in_a, in_b,
        input  busy, done, out_c
    );

    modport slave (
        input  start, signed_mode, in_a, in_b,
        output busy, done, out_c
    );
endinterface

// File: rtl/booth_seq_step.sv
// One combinational Booth step: recode, add/sub into A, arithmetic shift of {A,Q}.
// BOOTH_RADIX4_EN selects modified (radix-4) recoding with a 2-bit shift.
module booth_seq_step
    import mult_pkg::*;
#(
    parameter int E  = 9,
    parameter int AW = 9
) (
    input  logic [AW-1:0] a,
    input  logic [E:0]    q,
    input  logic [E-1:0]  m,
    output logic [AW-1:0] a_nxt,
    output logic [E:0]    q_nxt
);
    booth_op_t       op;
    logic [AW-1:0]   m1;
    logic [AW-1:0]   sum;
    logic signed [AW+E:0] shifted;

`ifdef BOOTH_RADIX4_EN
    localparam int SH = 2;
    logic [AW-1:0] m2;
    // A carries one guard bit so that +/-2M cannot overflow.
    assign op = recode4(q[2:0]);
    assign m1 = {{(AW-E){m[E-1]}}, m};
    assign m2 = m1 << 1;
`else
    localparam int SH = 1;
    assign op = recode2(q[1:0]);
    assign m1 = m;
`endif

    always_comb begin
        sum = a;
        case (op)
            ADD1:    sum = a + m1;
            SUB1:    sum = a - m1;
`ifdef BOOTH_RADIX4_EN
            ADD2:    sum = a + m2;
            SUB2:    sum = a - m2;
`endif
            default: sum = a;
        endcase
    end

    assign shifted        = $signed({sum, q}) >>> SH;
    assign {a_nxt, q_nxt} = shifted;

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier with start/busy/done handshake and runtime signed mode.
// Define BOOTH_RADIX4_EN for radix-4 recoding (WIDTH must be even); default is radix-2.
module booth_seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    booth_seq_mult_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
    localparam int E  = WIDTH + 2;
    localparam int AW = E + 1;
    localparam int N  = E / 2;
    if (WIDTH % 2 != 0) begin : g_odd_width
        $error("booth_seq_mult: WIDTH must be even for radix-4");
    end
`else
    localparam int E  = WIDTH + 1;
    localparam int AW = E;
    localparam int N  = E;
`endif
    if (WIDTH < 2) begin : g_small_width
        $error("booth_seq_mult: WIDTH must be at least 2");
    end

    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

    state_t               state;
    logic [AW-1:0]        a_r, a_nxt;
    logic [E:0]           q_r, q_nxt;
    logic [E-1:0]         m_r;
    logic [CW-1:0]        cnt;
    logic                 busy_r, done_r;
    logic [2*WIDTH-1:0]   out_r;

    // One extra bit keeps unsigned operands positive inside the signed datapath.
    function automatic logic [E-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
        return {{(E-WIDTH){s & v[WIDTH-1]}}, v};
    endfunction

    booth_seq_step #(.E(E), .AW(AW)) u_step (
        .a     (a_r),
        .q     (q_r),
        .m     (m_r),
        .a_nxt (a_nxt),
        .q_nxt (q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            out_r  <= '0;
            cnt    <= '0;
            a_r    <= '0;
            q_r    <= '0;
            m_r    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r    <= '0;
                        q_r    <= {ext(bus.in_a, bus.signed_mode), 1'b0};
                        m_r    <= ext(bus.in_b, bus.signed_mode);
                        cnt    <= CW'(N - 1);
                        busy_r <= 1'b1;
                        state  <= ST_CALC;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    a_r <= a_nxt;
                    q_r <= q_nxt;
                    if (cnt == '0) begin
                        out_r  <= (2*WIDTH)'({a_nxt, q_nxt[E:1]});
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.out_c = out_r;

endmodule
